// File: rtl/handshake_sender.sv
// Source side of a four-phase req/ack crossing: one-word holding buffer, ack
// synchronizer (falling then rising edge), optional per-phase timeout.
module handshake_sender #(
  parameter int width          = 8,
  parameter int msb            = width - 1,
  parameter int timeout_cycles = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [msb:0] data_in,
  output logic         in_ready,
  output logic         overrun,
  output logic         xfer_req,
  output logic [msb:0] xfer_data,
  input  logic         xfer_ack,
  output logic         busy,
  output logic         done,
  output logic         timeout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] ABORT   = 2'd3;

  localparam bit          TO_EN   = (timeout_cycles != 0);
  localparam logic [15:0] TO_LAST = 16'(timeout_cycles - 1);

  logic         ack_f, ack_s;
  logic [1:0]   state;
  logic [msb:0] buf_data;
  logic         buf_vld;
  logic [15:0]  cnt;
  logic         req_q, done_q, timeout_q, overrun_q;
  logic [msb:0] data_q;
  logic         accept, to_hit, bypass;

  assign accept   = load & ~buf_vld;
  assign to_hit   = TO_EN && (cnt == TO_LAST);
  // An accepted word skips the buffer only when IDLE can launch it right away.
  assign bypass   = (state == IDLE) && !ack_s;

  assign in_ready  = ~buf_vld;
  assign overrun   = overrun_q;
  assign xfer_req  = req_q;
  assign xfer_data = data_q;
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign timeout   = timeout_q;

  always_ff @(negedge clk) begin
    if (reset) ack_f <= 1'b0;
    else       ack_f <= xfer_ack;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_s     <= 1'b0;
      state     <= IDLE;
      buf_data  <= '0;
      buf_vld   <= 1'b0;
      cnt       <= 16'd0;
      req_q     <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ack_s     <= ack_f;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= load & buf_vld;
      if (accept && !bypass) begin
        buf_data <= data_in;
        buf_vld  <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (!ack_s) begin
            if (buf_vld) begin
              req_q   <= 1'b1;
              data_q  <= buf_data;
              buf_vld <= 1'b0;
              cnt     <= 16'd0;
              state   <= REQ;
            end else if (accept) begin
              req_q  <= 1'b1;
              data_q <= data_in;
              cnt    <= 16'd0;
              state  <= REQ;
            end
          end
        end
        REQ: begin
          if (ack_s) begin
            req_q <= 1'b0;
            cnt   <= 16'd0;
            state <= RELEASE;
          end else if (to_hit) begin
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            state     <= ABORT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            done_q <= 1'b1;
            // Chain the buffered word on the completing edge.
            if (buf_vld) begin
              req_q   <= 1'b1;
              data_q  <= buf_data;
              buf_vld <= 1'b0;
              cnt     <= 16'd0;
              state   <= REQ;
            end else begin
              state <= IDLE;
            end
          end else if (to_hit) begin
            timeout_q <= 1'b1;
            state     <= ABORT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          if (!ack_s) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_sender.sv
// Directed bench for handshake_sender: expected launch words go into a queue,
// a monitor pops them on each xfer_req rise; a responder models the destination.
module tb_handshake_sender;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         xfer_ack = 1'b0;
  logic         in_ready, overrun, xfer_req, busy, done, timeout;
  logic [W-1:0] xfer_data;

  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;
  int           ovr_cnt = 0;
  bit           auto_ack = 1'b0;
  logic [W-1:0] exp_q[$];

  handshake_sender #(.width(W), .timeout_cycles(8)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .in_ready(in_ready), .overrun(overrun), .xfer_req(xfer_req),
    .xfer_data(xfer_data), .xfer_ack(xfer_ack), .busy(busy),
    .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk(name, done, 1);
  endtask

  // Scoreboard monitor: launch words, data stability, pulse counts.
  initial begin
    logic         prev;
    logic [W-1:0] held;
    prev = 1'b0;
    held = '0;
    forever begin
      @(posedge clk);
      #2;
      if (xfer_req === 1'b1 && prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL launch_unexpected got %0h expected none", xfer_data);
        end else begin
          chk("launch_data", xfer_data, exp_q.pop_front());
        end
        held = xfer_data;
      end else if (xfer_req === 1'b1) begin
        chk("data_stable", xfer_data, held);
      end
      if (done === 1'b1) done_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
      prev = xfer_req;
    end
  end

  // Destination model: ack 3 cycles after req rises, release 3 cycles after req falls.
  initial begin
    int hc, lc;
    hc = 0;
    lc = 0;
    forever begin
      @(posedge clk);
      #3;
      if (xfer_req === 1'b1) begin hc++; lc = 0; end
      else begin lc++; hc = 0; end
      if (auto_ack) begin
        if (hc == 3) xfer_ack = 1'b1;
        if (lc == 3 && xfer_ack) xfer_ack = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    // Reset state
    tick();
    tick();
    chk("rst_req", xfer_req, 0);
    chk("rst_data", xfer_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    auto_ack = 1'b1;
    tick();

    // 1: single transfer
    d0 = done_cnt;
    load = 1'b1; data_in = 8'hA5; exp_q.push_back(8'hA5);
    tick();
    load = 1'b0;
    chk("t1_req", xfer_req, 1);
    chk("t1_busy", busy, 1);
    chk("t1_data", xfer_data, 8'hA5);
    wait_done("t1_done");
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_done_cnt", done_cnt - d0, 1);

    // 2: back-to-back with overrun
    d0 = done_cnt;
    load = 1'b1; data_in = 8'h11; exp_q.push_back(8'h11);
    tick();
    chk("t2_in_ready_free", in_ready, 1);
    data_in = 8'h22; exp_q.push_back(8'h22);
    tick();
    data_in = 8'h33;
    tick();
    load = 1'b0;
    chk("t2_overrun", overrun, 1);
    chk("t2_in_ready_full", in_ready, 0);
    chk("t2_data_held", xfer_data, 8'h11);
    wait_done("t2_done1");
    chk("t2_chain_req", xfer_req, 1);
    chk("t2_chain_data", xfer_data, 8'h22);
    chk("t2_in_ready_after", in_ready, 1);
    tick();
    wait_done("t2_done2");
    tick();
    chk("t2_idle", busy, 0);
    chk("t2_done_cnt", done_cnt - d0, 2);
    chk("t2_ovr_cnt", ovr_cnt, 1);

    // 3: timeout with ack never rising
    auto_ack = 1'b0;
    load = 1'b1; data_in = 8'h77; exp_q.push_back(8'h77);
    tick();
    load = 1'b0;
    n = 0;
    while (timeout !== 1'b1 && n < 30) begin tick(); n++; end
    chk("t3_timeout_cycle", n, 8);
    chk("t3_req_low", xfer_req, 0);
    chk("t3_abort_busy", busy, 1);
    tick();
    chk("t3_idle", busy, 0);
    chk("t3_pulse_end", timeout, 0);

    // 4: late ack after abort, buffered word sent afterwards
    d0 = done_cnt;
    load = 1'b1; data_in = 8'h44; exp_q.push_back(8'h44);
    tick();
    data_in = 8'h55; exp_q.push_back(8'h55);
    tick();
    load = 1'b0;
    n = 1;
    while (timeout !== 1'b1 && n < 30) begin tick(); n++; end
    chk("t4_timeout_cycle", n, 8);
    xfer_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_req", xfer_req, 0);
    end
    xfer_ack = 1'b0;
    auto_ack = 1'b1;
    tick();
    chk("t4_req_wait", xfer_req, 0);
    tick();
    chk("t4_req_launch", xfer_req, 1);
    chk("t4_data", xfer_data, 8'h55);
    wait_done("t4_done");
    tick();
    chk("t4_done_cnt", done_cnt - d0, 1);

    // 5: reset while in RELEASE with buffer valid
    load = 1'b1; data_in = 8'h66; exp_q.push_back(8'h66);
    tick();
    data_in = 8'h99;
    tick();
    load = 1'b0;
    chk("t5_buffered", in_ready, 0);
    n = 0;
    while (xfer_req !== 1'b0 && n < 20) begin tick(); n++; end
    chk("t5_release_busy", busy, 1);
    chk("t5_release_buf", in_ready, 0);
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_req", xfer_req, 0);
    chk("t5_data", xfer_data, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    repeat (10) tick();
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_still_idle", busy, 0);

    // 6: ack stuck high from reset
    auto_ack = 1'b0;
    xfer_ack = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    load = 1'b1; data_in = 8'h5A; exp_q.push_back(8'h5A);
    tick();
    load = 1'b0;
    chk("t6_no_req", xfer_req, 0);
    chk("t6_buffered", in_ready, 0);
    chk("t6_idle", busy, 0);
    tick();
    tick();
    chk("t6_still_no_req", xfer_req, 0);
    xfer_ack = 1'b0;
    auto_ack = 1'b1;
    tick();
    chk("t6_req_wait", xfer_req, 0);
    tick();
    chk("t6_req_launch", xfer_req, 1);
    chk("t6_data", xfer_data, 8'h5A);
    wait_done("t6_done");
    tick();
    chk("t6_idle_end", busy, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
